virtio_notify_sched: RTL and testbench

Virtqueue notification scheduler between the virtio CSR block and the DMA thread engine. It records queue-notify writes as per-queue pending bits and tracks which queues are in service. It round-robin arbitrates eligible queues onto a single grant channel, and clears in-service state on engine completion. It is the RTL replacement for the testbench-level pending-notification bookkeeping used in the QEMU/HDL co-simulation flow.

---
 rtl/virtio_notify_sched.sv | 132 +++++++++++++
 tb/tb_virtio_notify_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/virtio_notify_sched.sv
// Virtqueue notification scheduler: per-queue pending/busy tracking and a
// round-robin, never-withdrawn grant offer towards the DMA thread engine.
module virtio_notify_sched #(
  parameter int unsigned NUM_QUEUES = 3,
  parameter int unsigned QIDX_W     = 16,
  parameter int unsigned GIDX_W     = $clog2(NUM_QUEUES)
) (
  input  logic                  clk,
  input  logic                  csr_rst,
  input  logic                  notify_valid,
  input  logic [QIDX_W-1:0]     notify_qidx,
  input  logic [NUM_QUEUES-1:0] queue_enable,
  output logic                  grant_valid,
  output logic [GIDX_W-1:0]     grant_qidx,
  input  logic                  grant_ready,
  input  logic                  done_valid,
  input  logic [QIDX_W-1:0]     done_qidx,
  output logic [NUM_QUEUES-1:0] pending,
  output logic [NUM_QUEUES-1:0] busy,
  output logic                  err_pulse,
  output logic [31:0]           grant_count
);

  typedef enum logic {StIdle, StOffer} state_e;

  state_e                  state_q, state_d;
  logic [NUM_QUEUES-1:0]   pending_q, pending_d;
  logic [NUM_QUEUES-1:0]   busy_q, busy_d;
  logic [GIDX_W-1:0]       grant_qidx_q, grant_qidx_d;
  logic [GIDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [31:0]             count_q, count_d;
  logic                    err_q, err_d;

  logic                    notify_hit, done_hit, handshake;
  logic [GIDX_W-1:0]       notify_idx, done_idx;
  logic [NUM_QUEUES-1:0]   notify_set, done_clr, hs_set, eligible;
  logic                    found;
  logic [GIDX_W-1:0]       pick;

  assign notify_hit = notify_valid && (notify_qidx < QIDX_W'(NUM_QUEUES));
  assign done_hit   = done_valid && (done_qidx < QIDX_W'(NUM_QUEUES));
  assign notify_idx = notify_qidx[GIDX_W-1:0];
  assign done_idx   = done_qidx[GIDX_W-1:0];
  assign handshake  = (state_q == StOffer) && grant_ready;
  assign eligible   = pending_q & ~busy_q & queue_enable;

  // Decode the per-queue set/clear strobes for this cycle.
  always_comb begin
    notify_set = '0;
    done_clr   = '0;
    hs_set     = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (notify_hit && notify_idx == GIDX_W'(q) && queue_enable[q]) notify_set[q] = 1'b1;
      if (done_hit && done_idx == GIDX_W'(q) && busy_q[q])           done_clr[q]   = 1'b1;
      if (handshake && grant_qidx_q == GIDX_W'(q))                   hs_set[q]     = 1'b1;
    end
  end

  // Set beats clear on pending; disable masks pending but leaves busy alone.
  assign pending_d = ((pending_q & ~hs_set) | notify_set) & queue_enable;
  assign busy_d    = (busy_q & ~done_clr) | hs_set;
  assign err_d     = (notify_valid && (notify_set == '0)) || (done_valid && (done_clr == '0));

  // Round-robin pick: first eligible at or above rr_ptr, else first from zero.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (!found && eligible[q] && GIDX_W'(q) >= rr_ptr_q) begin
        found = 1'b1;
        pick  = GIDX_W'(q);
      end
    end
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (!found && eligible[q]) begin
        found = 1'b1;
        pick  = GIDX_W'(q);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_qidx_d = grant_qidx_q;
    rr_ptr_d     = rr_ptr_q;
    count_d      = count_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_qidx_d = pick;
          state_d      = StOffer;
        end
      end
      StOffer: begin
        if (grant_ready) begin
          state_d  = StIdle;
          rr_ptr_d = (grant_qidx_q == GIDX_W'(NUM_QUEUES - 1)) ? '0 : grant_qidx_q + 1'b1;
          count_d  = count_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge csr_rst) begin
    if (csr_rst) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      busy_q       <= '0;
      grant_qidx_q <= '0;
      rr_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      grant_qidx_q <= grant_qidx_d;
      rr_ptr_q     <= rr_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  assign grant_valid = (state_q == StOffer);
  assign grant_qidx  = grant_qidx_q;
  assign pending     = pending_q;
  assign busy        = busy_q;
  assign err_pulse   = err_q;
  assign grant_count = count_q;

endmodule

// File: tb/tb_virtio_notify_sched.sv
// Directed bench for virtio_notify_sched: grants and error pulses are checked
// by a negedge monitor against queues filled by the stimulus process.
module tb_virtio_notify_sched;

  logic        clk = 1'b0;
  logic        csr_rst;
  logic        notify_valid;
  logic [15:0] notify_qidx;
  logic [2:0]  queue_enable;
  logic        grant_valid;
  logic [1:0]  grant_qidx;
  logic        grant_ready;
  logic        done_valid;
  logic [15:0] done_qidx;
  logic [2:0]  pending;
  logic [2:0]  busy;
  logic        err_pulse;
  logic [31:0] grant_count;

  int tests = 0;
  int fails = 0;
  int exp_grant[$];
  int exp_err[$];

  virtio_notify_sched #(.NUM_QUEUES(3), .QIDX_W(16)) dut (
    .clk          (clk),
    .csr_rst      (csr_rst),
    .notify_valid (notify_valid),
    .notify_qidx  (notify_qidx),
    .queue_enable (queue_enable),
    .grant_valid  (grant_valid),
    .grant_qidx   (grant_qidx),
    .grant_ready  (grant_ready),
    .done_valid   (done_valid),
    .done_qidx    (done_qidx),
    .pending      (pending),
    .busy         (busy),
    .err_pulse    (err_pulse),
    .grant_count  (grant_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!csr_rst) begin
      if (grant_valid && grant_ready) begin
        tests++;
        if (exp_grant.size() == 0) begin
          fails++;
          $display("FAIL grant_unexpected: got qidx %0d, none expected", grant_qidx);
        end else begin
          int e;
          e = exp_grant.pop_front();
          if (int'(grant_qidx) != e) begin
            fails++;
            $display("FAIL grant_order: got qidx %0d, expected %0d", grant_qidx, e);
          end
        end
      end
      if (err_pulse) begin
        tests++;
        if (exp_err.size() == 0) begin
          fails++;
          $display("FAIL err_unexpected: got err_pulse 1, expected 0");
        end else begin
          void'(exp_err.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic notify(input int q);
    notify_valid = 1'b1;
    notify_qidx  = 16'(q);
    tick();
    notify_valid = 1'b0;
  endtask

  task automatic done(input int q);
    done_valid = 1'b1;
    done_qidx  = 16'(q);
    tick();
    done_valid = 1'b0;
  endtask

  initial begin
    csr_rst      = 1'b1;
    notify_valid = 1'b0;
    notify_qidx  = '0;
    queue_enable = 3'b111;
    grant_ready  = 1'b0;
    done_valid   = 1'b0;
    done_qidx    = '0;
    tick();
    tick();
    check("rst_grant_valid", 32'(grant_valid), 0);
    check("rst_grant_qidx", 32'(grant_qidx), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_pulse), 0);
    check("rst_count", grant_count, 0);
    csr_rst = 1'b0;
    tick();

    // Single notify: 2-cycle notify-to-offer latency.
    exp_grant.push_back(1);
    notify(1);
    check("t1_pending", 32'(pending), 32'b010);
    check("t1_gv_early", 32'(grant_valid), 0);
    tick();
    check("t1_gv", 32'(grant_valid), 1);
    check("t1_qidx", 32'(grant_qidx), 1);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    check("t1_pending_hs", 32'(pending), 0);
    check("t1_busy_hs", 32'(busy), 32'b010);
    check("t1_count", grant_count, 1);
    check("t1_gv_hs", 32'(grant_valid), 0);
    done(1);
    check("t1_busy_done", 32'(busy), 0);

    // Round-robin order, twice, with rr_ptr wrapping.
    for (int round = 0; round < 2; round++) begin
      grant_ready = 1'b1;
      for (int q = 0; q < 3; q++) exp_grant.push_back(q);
      for (int q = 0; q < 3; q++) notify(q);
      repeat (6) tick();
      grant_ready = 1'b0;
      check("t2_busy", 32'(busy), 32'b111);
      check("t2_pending", 32'(pending), 0);
      check("t2_count", grant_count, 32'(4 + 3 * round));
      for (int q = 0; q < 3; q++) done(q);
      check("t2_busy_done", 32'(busy), 0);
    end

    // Notify to a busy queue is held until done, then re-granted once.
    grant_ready = 1'b1;
    exp_grant.push_back(2);
    notify(2);
    repeat (3) tick();
    check("t3_busy", 32'(busy), 32'b100);
    notify(2);
    repeat (4) tick();
    check("t3_gv_held", 32'(grant_valid), 0);
    check("t3_pending_held", 32'(pending), 32'b100);
    grant_ready = 1'b0;
    exp_grant.push_back(2);
    done(2);
    check("t3_busy_clr", 32'(busy), 0);
    check("t3_gv_after_done", 32'(grant_valid), 0);
    tick();
    check("t3_gv_regrant", 32'(grant_valid), 1);
    check("t3_qidx_regrant", 32'(grant_qidx), 2);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    check("t3_count", grant_count, 9);
    check("t3_busy_hs", 32'(busy), 32'b100);
    check("t3_pending_hs", 32'(pending), 0);
    repeat (3) tick();
    check("t3_no_second", 32'(grant_valid), 0);
    done(2);

    // Offer held stable through notify and disable; pending q0 survives.
    exp_grant.push_back(1);
    exp_grant.push_back(0);
    notify(1);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        notify_valid = 1'b1;
        notify_qidx  = 16'd0;
      end else if (i == 1) begin
        notify_valid = 1'b0;
        queue_enable = 3'b101;
      end
      tick();
      check("t4_gv_hold", 32'(grant_valid), 1);
      check("t4_qidx_hold", 32'(grant_qidx), 1);
    end
    check("t4_pending", 32'(pending), 32'b001);
    grant_ready = 1'b1;
    repeat (3) tick();
    grant_ready = 1'b0;
    check("t4_busy", 32'(busy), 32'b011);
    check("t4_pending_after", 32'(pending), 0);
    check("t4_count", grant_count, 11);
    queue_enable = 3'b111;
    done(0);
    done(1);

    // Illegal notify, illegal done, and both together.
    exp_err.push_back(1);
    notify(5);
    check("t5_err_notify", 32'(err_pulse), 1);
    tick();
    check("t5_err_clear1", 32'(err_pulse), 0);
    exp_err.push_back(1);
    done(0);
    check("t5_err_done", 32'(err_pulse), 1);
    tick();
    check("t5_err_clear2", 32'(err_pulse), 0);
    check("t5_pending", 32'(pending), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_count", grant_count, 11);
    exp_err.push_back(1);
    notify_valid = 1'b1;
    notify_qidx  = 16'd7;
    done_valid   = 1'b1;
    done_qidx    = 16'd2;
    tick();
    notify_valid = 1'b0;
    done_valid   = 1'b0;
    check("t5_err_both", 32'(err_pulse), 1);
    tick();
    check("t5_err_single", 32'(err_pulse), 0);

    // Asynchronous reset mid-offer with busy=101.
    grant_ready = 1'b1;
    exp_grant.push_back(0);
    exp_grant.push_back(2);
    notify(0);
    notify(2);
    repeat (4) tick();
    grant_ready = 1'b0;
    check("t6_busy", 32'(busy), 32'b101);
    check("t6_count", grant_count, 13);
    notify(1);
    tick();
    check("t6_gv_offer", 32'(grant_valid), 1);
    check("t6_qidx_offer", 32'(grant_qidx), 1);
    #2 csr_rst = 1'b1;
    #1;
    check("t6_rst_gv", 32'(grant_valid), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_pending", 32'(pending), 0);
    check("t6_rst_count", grant_count, 0);
    check("t6_rst_qidx", 32'(grant_qidx), 0);
    tick();
    csr_rst = 1'b0;
    tick();
    exp_grant.push_back(0);
    notify(0);
    check("t6_post_gv0", 32'(grant_valid), 0);
    tick();
    check("t6_post_gv1", 32'(grant_valid), 1);
    check("t6_post_qidx", 32'(grant_qidx), 0);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    check("t6_post_count", grant_count, 1);
    check("t6_post_busy", 32'(busy), 32'b001);
    tick();

    check("grants_outstanding", 32'(exp_grant.size()), 0);
    check("errs_outstanding", 32'(exp_err.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
